// File: rtl/vpl_loop_ctrl_if.sv
// Command/response and kernel-control bundle for vpl_loop_ctrl.
// master: host plus kernel side; slave: the run controller.
interface vpl_loop_ctrl_if #(
    parameter int unsigned RES_W = 32,
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             kernel_rst;
    logic             kernel_halt;
    logic [RES_W-1:0] kernel_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic [CNT_W-1:0] rsp_cycles;
    logic             rsp_timeout;
    logic             busy;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        input  kernel_rst,
        output kernel_halt,
        output kernel_result,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_result,
        input  rsp_cycles,
        input  rsp_timeout,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        output kernel_rst,
        input  kernel_halt,
        input  kernel_result,
        output rsp_valid,
        input  rsp_ready,
        output rsp_result,
        output rsp_cycles,
        output rsp_timeout,
        output busy
    );
endinterface

// File: rtl/vpl_loop_ctrl.sv
// Run controller for a VPL loop kernel: holds the kernel in reset until a
// run command arrives, counts RUN cycles until halt, then returns the
// captured result and cycle count on a valid/ready response channel.
// Optional watchdog: define VPL_LOOP_CTRL_WATCHDOG_EN to end runs after
// TIMEOUT_CYCLES; without it the cycle counter saturates instead.
module vpl_loop_ctrl #(
    parameter int unsigned RES_W          = 32,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           reset,
    vpl_loop_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kernel_rst_q, kernel_rst_d;
    logic [RES_W-1:0] rsp_result_q, rsp_result_d;
    logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;

`ifdef VPL_LOOP_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic rsp_timeout_q, rsp_timeout_d;

    // Timeout flag register; only exists when the watchdog is built in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // State, counter and response registers; reset also re-asserts kernel reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            kernel_rst_q <= 1'b1;
            rsp_result_q <= '0;
            rsp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kernel_rst_q <= kernel_rst_d;
            rsp_result_q <= rsp_result_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

    // Next-state logic: accept in IDLE, count/capture in RUN, hand off in DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kernel_rst_d = kernel_rst_q;
        rsp_result_d = rsp_result_q;
        rsp_cycles_d = rsp_cycles_q;
`ifdef VPL_LOOP_CTRL_WATCHDOG_EN
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    kernel_rst_d = 1'b0;
                end
            end
            RUN: begin
                // Halt has priority over the watchdog when both land together.
                if (bus.kernel_halt) begin
                    state_d      = DONE;
                    rsp_result_d = bus.kernel_result;
                    rsp_cycles_d = cnt_q;
`ifdef VPL_LOOP_CTRL_WATCHDOG_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = DONE;
                    rsp_result_d  = bus.kernel_result;
                    rsp_cycles_d  = TO_CNT;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d      = IDLE;
                    kernel_rst_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                kernel_rst_d = 1'b1;
            end
        endcase
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.kernel_rst = kernel_rst_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_vpl_loop_ctrl.sv
// Directed bench for vpl_loop_ctrl with a behavioural kernel model.
// Watchdog scenarios are built when VPL_LOOP_CTRL_WATCHDOG_EN is defined,
// counter saturation scenarios otherwise.
module tb_vpl_loop_ctrl;

    localparam int unsigned TB_RES_W = 32;
    localparam int unsigned TB_CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int vecs = 0;
    int errs = 0;

    // Kernel model: counts edges since release; halts once kcnt reaches halt_at.
    int unsigned kcnt     = 0;
    int unsigned halt_at  = 0;
    bit          never    = 1'b0;
    logic [31:0] kbase    = '0;
    logic [31:0] kstep    = '0;

    vpl_loop_ctrl_if #(.RES_W(TB_RES_W), .CNT_W(TB_CNT_W)) bus ();

    vpl_loop_ctrl #(
        .RES_W(TB_RES_W),
        .CNT_W(TB_CNT_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.kernel_rst) kcnt <= 0;
        else                kcnt <= kcnt + 1;
    end

    assign bus.kernel_halt   = !bus.kernel_rst && !never && (kcnt >= halt_at);
    assign bus.kernel_result = kbase + kstep * kcnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Steps until rsp_valid or max edges; n = edges taken after the accept.
    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        vecs++; if (bus.kernel_rst !== 1'b1) begin errs++; $display("FAIL reset_kernel_rst: got %b want 1", bus.kernel_rst); end
        vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        vecs++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vecs++; if (bus.rsp_result !== 32'h0) begin errs++; $display("FAIL reset_rsp_result: got %h want 0", bus.rsp_result); end
        vecs++; if (bus.rsp_cycles !== 4'd0) begin errs++; $display("FAIL reset_rsp_cycles: got %0d want 0", bus.rsp_cycles); end
        vecs++; if (bus.rsp_timeout !== 1'b0) begin errs++; $display("FAIL reset_rsp_timeout: got %b want 0", bus.rsp_timeout); end
        reset = 1'b0;
        step();
        vecs++; if (bus.cmd_ready !== 1'b1 || bus.kernel_rst !== 1'b1) begin errs++; $display("FAIL idle_after_reset: got rdy=%b krst=%b want 1 1", bus.cmd_ready, bus.kernel_rst); end
    endtask

    task automatic test_basic_run();
        halt_at = 3; never = 1'b0; kbase = 32'd0; kstep = 32'd2;
        accept();
        vecs++; if (bus.kernel_rst !== 1'b0) begin errs++; $display("FAIL basic_release: got krst=%b want 0", bus.kernel_rst); end
        vecs++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL basic_busy: got busy=%b rdy=%b want 1 0", bus.busy, bus.cmd_ready); end
        for (int i = 1; i <= 3; i++) begin
            step();
            vecs++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: edge %0d got %b want 0", i, bus.rsp_valid); end
        end
        step();
        vecs++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL basic_valid_e4: got %b want 1", bus.rsp_valid); end
        vecs++; if (bus.rsp_result !== 32'd6) begin errs++; $display("FAIL basic_result: got %0d want 6", bus.rsp_result); end
        vecs++; if (bus.rsp_cycles !== 4'd3) begin errs++; $display("FAIL basic_cycles: got %0d want 3", bus.rsp_cycles); end
        vecs++; if (bus.rsp_timeout !== 1'b0) begin errs++; $display("FAIL basic_timeout: got %b want 0", bus.rsp_timeout); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        vecs++; if (bus.rsp_valid !== 1'b0 || bus.kernel_rst !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            errs++; $display("FAIL basic_handshake: got v=%b krst=%b rdy=%b want 0 1 1", bus.rsp_valid, bus.kernel_rst, bus.cmd_ready);
        end
    endtask

    task automatic test_hold();
        int n;
        halt_at = 3; never = 1'b0; kbase = 32'd0; kstep = 32'd2;
        accept();
        wait_rsp(20, n);
        vecs++; if (n != 4) begin errs++; $display("FAIL hold_latency: got %0d edges want 4", n); end
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd6 || bus.rsp_cycles !== 4'd3 || bus.rsp_timeout !== 1'b0) begin
                errs++; $display("FAIL hold_stable: cycle %0d got v=%b r=%0d c=%0d t=%b want 1 6 3 0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_cycles, bus.rsp_timeout);
            end
            vecs++; if (bus.cmd_ready !== 1'b0 || bus.kernel_rst !== 1'b0) begin errs++; $display("FAIL hold_cmd_ignored: got rdy=%b krst=%b want 0 0", bus.cmd_ready, bus.kernel_rst); end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        vecs++; if (bus.rsp_valid !== 1'b0 || bus.kernel_rst !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            errs++; $display("FAIL hold_handshake: got v=%b krst=%b rdy=%b want 0 1 1", bus.rsp_valid, bus.kernel_rst, bus.cmd_ready);
        end
        step();
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL hold_no_queue: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_halt_immediate();
        int n;
        halt_at = 0; never = 1'b0; kbase = 32'h1234; kstep = 32'd1;
        accept();
        wait_rsp(20, n);
        vecs++; if (n != 1) begin errs++; $display("FAIL imm_latency: got %0d edges want 1", n); end
        vecs++; if (bus.rsp_cycles !== 4'd0) begin errs++; $display("FAIL imm_cycles: got %0d want 0", bus.rsp_cycles); end
        vecs++; if (bus.rsp_result !== 32'h1234) begin errs++; $display("FAIL imm_result: got %h want 1234", bus.rsp_result); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        halt_at = 2; never = 1'b0; kbase = 32'd100; kstep = 32'd1;
        accept();
        wait_rsp(20, n);
        // Present both response accept and a new command on the same edge.
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        vecs++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap: got rdy=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); end
        step();
        bus.cmd_valid = 1'b0;
        vecs++; if (bus.busy !== 1'b1 || bus.kernel_rst !== 1'b0) begin errs++; $display("FAIL b2b_accept: got busy=%b krst=%b want 1 0", bus.busy, bus.kernel_rst); end
        wait_rsp(20, n);
        vecs++; if (n != 3 || bus.rsp_cycles !== 4'd2 || bus.rsp_result !== 32'd102) begin
            errs++; $display("FAIL b2b_second_run: got n=%0d c=%0d r=%0d want 3 2 102", n, bus.rsp_cycles, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

`ifdef VPL_LOOP_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        never = 1'b1; kbase = 32'h55; kstep = 32'd0;
        accept();
        wait_rsp(40, n);
        vecs++; if (n != 8) begin errs++; $display("FAIL wd_latency: got %0d edges want 8", n); end
        vecs++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_cycles !== 4'd8 || bus.rsp_result !== 32'h55) begin
            errs++; $display("FAIL wd_timeout: got t=%b c=%0d r=%h want 1 8 55", bus.rsp_timeout, bus.rsp_cycles, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        // Halt becomes visible on the same edge the watchdog would fire.
        never = 1'b0; halt_at = 7; kbase = 32'hAA;
        accept();
        wait_rsp(40, n);
        vecs++; if (n != 8) begin errs++; $display("FAIL wd_collide_latency: got %0d edges want 8", n); end
        vecs++; if (bus.rsp_timeout !== 1'b0 || bus.rsp_cycles !== 4'd7 || bus.rsp_result !== 32'hAA) begin
            errs++; $display("FAIL wd_collide: got t=%b c=%0d r=%h want 0 7 aa", bus.rsp_timeout, bus.rsp_cycles, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask
`else
    task automatic test_saturate();
        int n;
        never = 1'b0; halt_at = 20; kbase = 32'd0; kstep = 32'd1;
        accept();
        wait_rsp(60, n);
        vecs++; if (n != 21) begin errs++; $display("FAIL sat_latency: got %0d edges want 21", n); end
        vecs++; if (bus.rsp_cycles !== 4'd15 || bus.rsp_timeout !== 1'b0 || bus.rsp_result !== 32'd20) begin
            errs++; $display("FAIL sat_cycles: got c=%0d t=%b r=%0d want 15 0 20", bus.rsp_cycles, bus.rsp_timeout, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_midrun();
        int n;
        never = 1'b0; halt_at = 3; kbase = 32'd7; kstep = 32'd1;
        accept();
        step();
        step();
        reset = 1'b1;
        #1;
        vecs++; if (bus.kernel_rst !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL midrun_async: got krst=%b rdy=%b busy=%b want 1 1 0", bus.kernel_rst, bus.cmd_ready, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL midrun_no_rsp: cycle %0d got %b want 0", i, bus.rsp_valid); end
        end
        reset = 1'b0;
        step();
        accept();
        wait_rsp(20, n);
        vecs++; if (n != 4 || bus.rsp_cycles !== 4'd3 || bus.rsp_result !== 32'd10) begin
            errs++; $display("FAIL midrun_rerun: got n=%0d c=%0d r=%0d want 4 3 10", n, bus.rsp_cycles, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic_run();
        test_hold();
        test_halt_immediate();
        test_back_to_back();
`ifdef VPL_LOOP_CTRL_WATCHDOG_EN
        test_watchdog();
`else
        test_saturate();
`endif
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
